spi_frame_writer: RTL

Parametrised serial-to-parallel line writer for the radar STFT input path. It deserialises an SPI MOSI stream into DW-bit words. Each word is taken from a FRAME_BITS-long frame and written to a DEPTH-line image buffer with a one-cycle write strobe. After the last line of an image it signals image completion, and it can alternate between two buffer banks so the downstream STFT engine reads one image while the next is being filled.

---
 rtl/spi_frame_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_frame_writer.sv
// SPI MOSI deserialiser that writes DW-bit line words into a DEPTH-line image buffer.
// It signals image completion after a programmable drain delay and can ping-pong between two banks.
module spi_frame_writer #(
  parameter int DW         = 20,
  parameter int FRAME_BITS = 24,
  parameter int DEPTH      = 20,
  parameter int AW         = 5,
  parameter int MSB_FIRST  = 1,
  parameter int DONE_DLY   = 2,
  parameter int PINGPONG   = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic          MOSI,
  output logic [DW-1:0] oDATA,
  output logic          oWr_EN,
  output logic [AW-1:0] oWr_ADDR,
  output logic          oBANK,
  output logic          oWr_DONE,
  output logic          oFRAME_ACT
);

  localparam int BW  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DCW = (DONE_DLY > 1) ? $clog2(DONE_DLY) : 1;

  localparam logic [BW-1:0]  BCNT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0]  BCNT_WORD = BW'(DW - 1);
  localparam logic [BW-1:0]  BCNT_ONE  = BW'(1);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0]  ADDR_ONE  = AW'(1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'((DONE_DLY > 0) ? (DONE_DLY - 1) : 0);
  localparam logic [DCW-1:0] DCNT_ONE  = DCW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [BW-1:0]  bcnt_r;
  logic [BW-1:0]  bcnt_nxt_s;
  logic [DW-1:0]  sr_r;
  logic [DW-1:0]  sr_nxt_s;
  logic [DW-1:0]  data_r;
  logic [AW-1:0]  addr_r;
  logic [DCW-1:0] dcnt_r;
  logic [DCW-1:0] dcnt_nxt_s;
  logic           wr_en_r;
  logic           bank_r;
  logic           done_r;
  logic           frame_act_r;
  logic           word_done_s;
  logic           clr_s;

  assign clr_s       = iRST | iCLR;
  assign word_done_s = iEN & (bcnt_r == BCNT_WORD);

  // Bit counter advance and shift-register load for the current enabled cycle
  always_comb begin
    bcnt_nxt_s = bcnt_r;
    sr_nxt_s   = sr_r;
    if (iEN) begin
      if (bcnt_r == BCNT_LAST) begin
        bcnt_nxt_s = '0;
      end else begin
        bcnt_nxt_s = bcnt_r + BCNT_ONE;
      end
      if (bcnt_r <= BCNT_WORD) begin
        if (MSB_FIRST != 0) begin
          sr_nxt_s = {sr_r[DW-2:0], MOSI};
        end else begin
          sr_nxt_s = {MOSI, sr_r[DW-1:1]};
        end
      end else begin
        sr_nxt_s = sr_r;
      end
    end else begin
      bcnt_nxt_s = bcnt_r;
    end
  end

  // Image-completion sequencer: wait for last line, drain, then pulse done
  always_comb begin
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    case (state_r)
      RUN: begin
        dcnt_nxt_s = '0;
        if (wr_en_r && (addr_r == ADDR_LAST)) begin
          if (DONE_DLY == 0) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (dcnt_r == DCNT_LAST) begin
          state_nxt_s = DONE;
          dcnt_nxt_s  = '0;
        end else begin
          state_nxt_s = DRAIN;
          dcnt_nxt_s  = dcnt_r + DCNT_ONE;
        end
      end
      DONE: begin
        state_nxt_s = RUN;
        dcnt_nxt_s  = '0;
      end
      default: begin
        state_nxt_s = RUN;
        dcnt_nxt_s  = '0;
      end
    endcase
  end

  // Capture datapath, line addressing and FSM state registers
  always_ff @(posedge iCLK) begin
    if (clr_s) begin
      state_r     <= RUN;
      bcnt_r      <= '0;
      sr_r        <= '0;
      data_r      <= '0;
      addr_r      <= '0;
      dcnt_r      <= '0;
      wr_en_r     <= 1'b0;
      bank_r      <= 1'b0;
      done_r      <= 1'b0;
      frame_act_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dcnt_r      <= dcnt_nxt_s;
      bcnt_r      <= bcnt_nxt_s;
      sr_r        <= sr_nxt_s;
      wr_en_r     <= word_done_s;
      done_r      <= (state_nxt_s == DONE);
      frame_act_r <= (bcnt_nxt_s != '0);
      if (word_done_s) begin
        data_r <= sr_nxt_s;
      end
      // Address is held for the strobe cycle and advances right after it
      if (wr_en_r) begin
        addr_r <= (addr_r == ADDR_LAST) ? '0 : (addr_r + ADDR_ONE);
      end
      if ((state_r == DONE) && (PINGPONG != 0)) begin
        bank_r <= ~bank_r;
      end
    end
  end

  assign oDATA      = data_r;
  assign oWr_EN     = wr_en_r;
  assign oWr_ADDR   = addr_r;
  assign oBANK      = bank_r;
  assign oWr_DONE   = done_r;
  assign oFRAME_ACT = frame_act_r;

endmodule
